// File: rtl/audio_dac_i2s_tx.sv
// audio_dac_i2s_tx
//
// Serializes 16-bit stereo sample pairs onto the codec DAC I2S lines and
// generates the codec bit clock and LR clock from state_clk. aud_lrck also
// serves as the IIR filter lr_clk, so each filtered pair comes back through
// this block once per frame. The sample side is a one-deep ready/valid
// holding register.
//
// Parameters
//   DIV         state_clk cycles per aud_bclk half-period (>= 2)
//
// Ports
//   state_clk   in   system clock, posedge
//   reset       in   asynchronous active-low reset
//   left_in     in   [15:0] left sample, 2's complement
//   right_in    in   [15:0] right sample, 2's complement
//   in_valid    in   sample pair present
//   in_ready    out  holding register empty
//   aud_bclk    out  codec bit clock, period 2*DIV
//   aud_lrck    out  codec LR clock, 0 = left slot
//   aud_dat     out  serial data, MSB first, one bclk after LRCK edge
//   frame_start out  one-cycle pulse on every shift-register load
//   underrun    out  one-cycle pulse when a load finds no pending pair
//
// Build option
//   AUDIO_TX_UNDERRUN_HOLD_EN  when defined, an underrun replays the last
//                              pair that was loaded normally; otherwise an
//                              underrun plays silence.

module audio_dac_i2s_tx #(
  parameter int DIV = 4
) (
  input  logic        state_clk,
  input  logic        reset,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        aud_bclk,
  output logic        aud_lrck,
  output logic        aud_dat,
  output logic        frame_start,
  output logic        underrun
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic [CW-1:0] div_cnt;
  logic          div_wrap;
  logic          bit_evt;
  logic [4:0]    p;
  logic [4:0]    p_next;
  logic          load;
  logic          capture;
  logic          pending;
  pair_t         hold_q;
  pair_t         fill;
  logic [31:0]   sr;

  assign div_wrap = (div_cnt == DIV_LAST);
  // bclk is high and about to toggle: this wrap is the falling edge.
  assign bit_evt  = div_wrap & aud_bclk;
  assign p_next   = p + 5'd1;
  // The load happens on the bit event that moves p from 0 to 1, so the
  // left MSB is on the wire during p=1, one bclk after LRCK fell at p=0.
  assign load     = bit_evt & (p == 5'd0);
  assign capture  = in_valid & ~pending;
  assign in_ready = ~pending;
  assign aud_dat  = sr[31];

  // bit clock divider
  always_ff @(posedge state_clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      aud_bclk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      aud_bclk <= ~aud_bclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // bit position and LR clock; LRCK is high for the right slot p=16..31,
  // i.e. it leads the right MSB (p=17) by one bit.
  always_ff @(posedge state_clk or negedge reset) begin
    if (!reset) begin
      p        <= '0;
      aud_lrck <= 1'b0;
    end else if (bit_evt) begin
      p        <= p_next;
      aud_lrck <= (p_next >= 5'd16);
    end
  end

  // one-deep holding register. Capture requires pending=0, so it can never
  // coincide with a consuming load; a coincident load is an underrun and the
  // freshly captured pair waits for the next frame.
  always_ff @(posedge state_clk or negedge reset) begin
    if (!reset) begin
      hold_q  <= '0;
      pending <= 1'b0;
    end else begin
      if (capture) begin
        hold_q  <= '{l: left_in, r: right_in};
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef AUDIO_TX_UNDERRUN_HOLD_EN
  // last normally loaded pair, replayed when the upstream starves
  pair_t last_q;

  always_ff @(posedge state_clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else if (load && pending) begin
      last_q <= hold_q;
    end
  end

  assign fill = last_q;
`else
  // starvation plays silence
  assign fill = '0;
`endif

  // output shift register {L, R}, MSB on the pin
  always_ff @(posedge state_clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= pending ? hold_q : fill;
    end else if (bit_evt) begin
      sr <= {sr[30:0], 1'b0};
    end
  end

  // status pulses, one state_clk wide
  always_ff @(posedge state_clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load & ~pending;
    end
  end

endmodule
